// File: rtl/ble_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ble_pkg
//  Description : Shared baseband definitions for the BLE RX PDU path:
//                deframer state encoding, header/CRC geometry and a helper
//                that right-aligns a partially filled LSB-first byte.
//  Revision    : 1.0  initial release
// ============================================================================
package ble_pkg;

    typedef enum logic [2:0] {
        ST_HDR0    = 3'd0,
        ST_HDR1    = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CRC     = 3'd3,
        ST_DONE    = 3'd4,
        ST_DROP    = 3'd5
    } ble_state_e;

    localparam int PDU_HDR_BYTES     = 2;
    localparam int CRC_BYTES_DEFAULT = 3;
    localparam int LEN_BYTE_IDX      = 1;

    // Bits enter at bit 7 and move down, so a byte holding (cnt+1) bits sits
    // in the top of the register; shifting right leaves zeros above it.
    function automatic logic [7:0] lsb_align(input logic [7:0] shift,
                                             input logic [2:0] bit_idx);
        return shift >> (3'd7 - bit_idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ble_pdu_deframer_if.sv
`default_nettype none
// ============================================================================
//  Module      : ble_pdu_deframer_if
//  Description : Minimal AXI-Stream bundle (tdata/tvalid/tready/tlast) with
//                configurable data width, used for both the 1-bit input
//                stream and the 8-bit byte stream of the deframer.
//  Revision    : 1.0  initial release
// ============================================================================
interface ble_pdu_deframer_if #(
    parameter int W = 8
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);

endinterface
`default_nettype wire

// File: rtl/bit_to_byte_lsb.sv
`default_nettype none
// ============================================================================
//  Module      : bit_to_byte_lsb
//  Description : Packs accepted bits LSB-first into bytes and holds each byte
//                in an AXI-Stream output register. A flush request emits the
//                current partial byte zero-padded in its upper bits.
//  Revision    : 1.0  initial release
// ============================================================================
module bit_to_byte_lsb
    import ble_pkg::*;
(
    input  wire logic       aclk,
    input  wire logic       aresetn,
    input  wire logic       restart,
    input  wire logic       bit_accept_i,
    input  wire logic       bit_data_i,
    input  wire logic       flush_i,
    input  wire logic       last_i,
    output logic            byte_full_o,
    output logic [7:0]      byte_value_o,
    output logic [7:0]      out_tdata_o,
    output logic            out_tvalid_o,
    output logic            out_tlast_o,
    input  wire logic       out_tready_i
);

    logic [7:0] shift_q;
    logic [7:0] shift_d;
    logic [2:0] bit_cnt_q;
    logic [7:0] tdata_q;
    logic       tvalid_q;
    logic       tlast_q;
    logic       w_emit;

    // Next shift value and the byte that would be emitted on this bit
    always_comb begin
        shift_d      = {bit_data_i, shift_q[7:1]};
        byte_full_o  = bit_accept_i && (bit_cnt_q == 3'd7);
        w_emit       = bit_accept_i && ((bit_cnt_q == 3'd7) || flush_i);
        byte_value_o = lsb_align(shift_d, bit_cnt_q);
    end

    // Shift register, bit counter and the output byte register
    always_ff @(posedge aclk) begin
        if (!aresetn || restart) begin
            shift_q   <= 8'd0;
            bit_cnt_q <= 3'd0;
            tdata_q   <= 8'd0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
        end else begin
            if (tvalid_q && out_tready_i) begin
                tvalid_q <= 1'b0;
            end
            if (bit_accept_i) begin
                shift_q   <= shift_d;
                bit_cnt_q <= w_emit ? 3'd0 : bit_cnt_q + 3'd1;
                if (w_emit) begin
                    tdata_q  <= byte_value_o;
                    tvalid_q <= 1'b1;
                    tlast_q  <= last_i;
                end
            end
        end
    end

    assign out_tdata_o  = tdata_q;
    assign out_tvalid_o = tvalid_q;
    assign out_tlast_o  = tlast_q;

endmodule
`default_nettype wire

// File: rtl/ble_pdu_deframer.sv
`default_nettype none
// ============================================================================
//  Module      : ble_pdu_deframer
//  Description : Consumes the de-whitened 1-bit RX stream, rebuilds bytes,
//                parses the 2-byte PDU header for LEN and forwards header,
//                payload and CRC bytes with tlast on the last CRC byte.
//                Oversized LEN and early input tlast end the frame early.
//  Revision    : 1.0  initial release
// ============================================================================
module ble_pdu_deframer
    import ble_pkg::*;
#(
    parameter int MAX_PAYLOAD = 255,
    parameter int CRC_BYTES   = CRC_BYTES_DEFAULT
) (
    input  wire logic          aclk,
    input  wire logic          aresetn,
    input  wire logic          restart,
    ble_pdu_deframer_if.slave  input_s,
    ble_pdu_deframer_if.master output_m,
    output logic [7:0]         frame_length,
    output logic               status_done,
    output logic               status_len_err,
    output logic               status_trunc
);

    localparam logic [8:0] c_max_len  = 9'(MAX_PAYLOAD);
    localparam logic [7:0] c_crc_last = 8'(CRC_BYTES - 1);

    ble_state_e state_q;
    ble_state_e state_d;
    logic [7:0] byte_cnt_q;
    logic [7:0] byte_cnt_d;
    logic [7:0] frame_length_q;
    logic [7:0] frame_length_d;
    logic       done_arm_q;
    logic       done_arm_d;
    logic       status_done_q;
    logic       status_done_d;
    logic       status_len_err_q;
    logic       status_len_err_d;
    logic       status_trunc_q;
    logic       status_trunc_d;

    logic       w_in_ready;
    logic       w_framing;
    logic       w_pack;
    logic       w_full;
    logic [7:0] w_byte;
    logic       w_crc_final;
    logic       w_trunc;
    logic       w_len_err;
    logic       w_last;
    logic       w_drop_end;
    logic       w_payload_end;
    logic       w_tlast_hs;
    logic [7:0] w_out_tdata;
    logic       w_out_tvalid;
    logic       w_out_tlast;

    // Decode of the current bit against state and counters
    assign w_framing     = (state_q == ST_HDR0) || (state_q == ST_HDR1) ||
                           (state_q == ST_PAYLOAD) || (state_q == ST_CRC);
    assign w_in_ready    = ((state_q == ST_DROP) || (state_q == ST_DONE)) ? 1'b1 : ~w_out_tvalid;
    assign w_pack        = input_s.tvalid && w_in_ready && w_framing;
    assign w_crc_final   = (state_q == ST_CRC) && w_full && (byte_cnt_q == c_crc_last);
    assign w_trunc       = w_pack && input_s.tlast && !w_crc_final;
    assign w_len_err     = (state_q == ST_HDR1) && w_full && !w_trunc &&
                           ({1'b0, w_byte} > c_max_len);
    assign w_last        = w_trunc || w_crc_final || w_len_err;
    assign w_drop_end    = (state_q == ST_DROP) && input_s.tvalid && input_s.tlast;
    assign w_payload_end = (state_q == ST_PAYLOAD) && w_full &&
                           (byte_cnt_q == frame_length_q - 8'd1);
    assign w_tlast_hs    = w_out_tvalid && output_m.tready && w_out_tlast;

    bit_to_byte_lsb u_packer (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .restart      (restart),
        .bit_accept_i (w_pack),
        .bit_data_i   (input_s.tdata[0]),
        .flush_i      (w_trunc),
        .last_i       (w_last),
        .byte_full_o  (w_full),
        .byte_value_o (w_byte),
        .out_tdata_o  (w_out_tdata),
        .out_tvalid_o (w_out_tvalid),
        .out_tlast_o  (w_out_tlast),
        .out_tready_i (output_m.tready)
    );

    // State register
    always_ff @(posedge aclk) begin
        if (!aresetn || restart) begin
            state_q <= ST_HDR0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: truncation overrides every framing transition
    always_comb begin
        state_d = state_q;
        if (w_trunc) begin
            state_d = ST_DONE;
        end else begin
            case (state_q)
                ST_HDR0:    if (w_full) state_d = ST_HDR1;
                ST_HDR1: begin
                    if (w_full) begin
                        if (w_len_err)           state_d = ST_DROP;
                        else if (w_byte == 8'd0) state_d = ST_CRC;
                        else                     state_d = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: if (w_payload_end) state_d = ST_CRC;
                ST_CRC:     if (w_crc_final)   state_d = ST_DONE;
                ST_DROP:    if (w_drop_end)    state_d = ST_DONE;
                ST_DONE:    state_d = ST_DONE;
                default:    state_d = ST_HDR0;
            endcase
        end
    end

    // Counters, captured LEN and status pulse next values
    always_comb begin
        byte_cnt_d     = byte_cnt_q;
        frame_length_d = frame_length_q;
        done_arm_d     = done_arm_q;
        if (w_tlast_hs) begin
            done_arm_d = 1'b0;
        end
        if (w_crc_final) begin
            done_arm_d = 1'b1;
        end
        if ((state_q == ST_HDR1) && w_full) begin
            frame_length_d = w_byte;
        end
        if ((state_q == ST_PAYLOAD) && w_full) begin
            byte_cnt_d = w_payload_end ? 8'd0 : byte_cnt_q + 8'd1;
        end
        if ((state_q == ST_CRC) && w_full) begin
            byte_cnt_d = byte_cnt_q + 8'd1;
        end
        status_done_d    = w_tlast_hs && done_arm_q;
        status_len_err_d = w_len_err;
        status_trunc_d   = w_trunc;
    end

    // Datapath registers
    always_ff @(posedge aclk) begin
        if (!aresetn || restart) begin
            byte_cnt_q       <= 8'd0;
            frame_length_q   <= 8'd0;
            done_arm_q       <= 1'b0;
            status_done_q    <= 1'b0;
            status_len_err_q <= 1'b0;
            status_trunc_q   <= 1'b0;
        end else begin
            byte_cnt_q       <= byte_cnt_d;
            frame_length_q   <= frame_length_d;
            done_arm_q       <= done_arm_d;
            status_done_q    <= status_done_d;
            status_len_err_q <= status_len_err_d;
            status_trunc_q   <= status_trunc_d;
        end
    end

    assign input_s.tready  = w_in_ready;
    assign output_m.tdata  = w_out_tdata;
    assign output_m.tvalid = w_out_tvalid;
    assign output_m.tlast  = w_out_tlast;
    assign frame_length    = frame_length_q;
    assign status_done     = status_done_q;
    assign status_len_err  = status_len_err_q;
    assign status_trunc    = status_trunc_q;

endmodule
`default_nettype wire
